// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM state and transaction owner encodings.
package cache_arb_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/cache_arbiter_arb_pick.sv
// Combinational grant selection between the I-cache and D-cache requesters.
// Build option CACHE_ARB_ROUND_ROBIN_EN alternates winners on a tie; otherwise D always wins.
module arb_pick
    import cache_arb_types::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_src
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_src   = last_grant;
        if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            grant_src = (arb_src_t'(last_grant) == SRC_I) ? logic'(SRC_D) : logic'(SRC_I);
`else
            grant_src = logic'(SRC_D);
`endif
        end else if (d_req) begin
            grant_src = logic'(SRC_D);
        end else if (i_req) begin
            grant_src = logic'(SRC_I);
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the L1 I-cache and D-cache, one line at a time.
// Tie-break policy is selected in arb_pick via CACHE_ARB_ROUND_ROBIN_EN.
module cache_arbiter
    import cache_arb_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    arb_src_t          owner_q, owner_d;
    arb_src_t          last_grant_q, last_grant_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic grant_valid;
    logic grant_src_w;

    arb_pick u_pick (
        .i_req       (i_read),
        .d_req       (d_read | d_write),
        .last_grant  (logic'(last_grant_q)),
        .grant_valid (grant_valid),
        .grant_src   (grant_src_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= SRC_I;
            last_grant_q <= SRC_I;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d      = arb_src_t'(grant_src_w);
                    last_grant_d = arb_src_t'(grant_src_w);
                    wdata_d      = d_wdata;
                    state_d      = BUSY;
                    // A simultaneous D read and write is treated as a write-back.
                    if (arb_src_t'(grant_src_w) == SRC_D) begin
                        addr_d     = d_address;
                        op_write_d = d_write;
                    end else begin
                        addr_d     = i_address;
                        op_write_d = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_read    = (state_q == BUSY) && !op_write_q;
        mem_write   = (state_q == BUSY) && op_write_q;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        i_resp      = (state_q == RESP) && (owner_q == SRC_I);
        d_resp      = (state_q == RESP) && (owner_q == SRC_D);
        i_rdata     = rdata_q;
        d_rdata     = rdata_q;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one physical-memory port between the L1 I-cache (read-only) and the L1 D-cache (read/write); the I-cache and D-cache sit behind the imem/dmem interfaces of cpu_datapath.
- Only one cacheline transaction is outstanding at a time.
- Requests and write data are latched at grant. Read data is registered, and the response is returned to the owning requester as a one-cycle pulse.

Parameters:
- LINE_W, 256, cacheline width in bits (data buses)
- ADDR_W, 32, address width in bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line-fill request; held high until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to the I-cache
- i_resp  out  1  one-cycle completion pulse to the I-cache
- d_read  in  1  D-cache line-fill request; held high until d_resp
- d_write  in  1  D-cache write-back request; held high until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  write-back line
- d_rdata  out  LINE_W  line returned to the D-cache
- d_resp  out  1  one-cycle completion pulse to the D-cache
- mem_read  out  1  read request to physical memory
- mem_write  out  1  write request to physical memory
- mem_address  out  ADDR_W  physical-memory address
- mem_wdata  out  LINE_W  physical-memory write data
- mem_rdata  in  LINE_W  physical-memory read data, valid with mem_resp
- mem_resp  in  1  physical-memory completion pulse

Behaviour:
- State machine (arb_state_t): IDLE, BUSY, RESP. Owner register: arb_src_t {SRC_I, SRC_D}. Also registers last_grant, op_write, addr_q, wdata_q and rdata_q.
- Reset (any time, including mid-transaction):
  - state=IDLE, last_grant=SRC_I.
  - All outputs 0, rdata_q=0.
  - The in-flight memory transaction is abandoned; the memory model is reset alongside.
- IDLE:
  - mem_read=mem_write=0.
  - With no request, stay in IDLE.
  - Only D requesting: grant D. Only I requesting: grant I.
  - Both requesting: D wins (fixed priority), unless the optional feature below is compiled in.
  - On grant, in the same edge:
    - latch owner, address, wdata and op_write.
    - op_write = d_write for D (write wins if d_read and d_write are both high), 0 for I.
    - go to BUSY and set last_grant=owner.
- BUSY:
  - mem_read = ~op_write and mem_write = op_write, both held constant for the whole of BUSY.
  - mem_address=addr_q, mem_wdata=wdata_q.
  - On mem_resp: rdata_q <= mem_rdata, go to RESP. Requester inputs are ignored during BUSY.
- RESP (exactly 1 cycle):
  - mem_read=mem_write=0.
  - The owner's x_resp=1; the other x_resp=0. x_rdata=rdata_q. rdata_q is written on writes too, so d_rdata after a write is don't-care.
  - Next state is IDLE. The requester drops its request on the same edge.
  - IDLE re-arbitrates on the following cycle, so no request is ever double-served.
- Latency:
  - Request to mem_read/mem_write: 1 cycle.
  - mem_resp to x_resp: 1 cycle.
  - Minimum request-to-response: 3 cycles with 1-cycle memory.
  - Back-to-back grants are separated by one IDLE cycle.
- Boundary conditions:
  - mem_resp in IDLE or RESP is ignored.
  - A requester that drops its request while in BUSY still receives its x_resp pulse.
  - i_rdata/d_rdata are always driven from rdata_q; only x_resp qualifies them.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the source that is not last_grant. After reset, D wins the first tie.
- Undefined: fixed D-over-I priority; last_grant is still maintained but unused.

Decomposition:
- Package cache_arb_types:
  - arb_state_t {IDLE, BUSY, RESP}
  - arb_src_t {SRC_I, SRC_D}
- One sub-module, arb_pick: combinational pick(i_req, d_req, last_grant) → {grant_valid, grant_src}. The macro is confined to this sub-module.
- FSM and datapath registers live in cache_arbiter.

Test Plan:
- I-only read at 0x0000_0040, memory latency 4 cycles with mem_rdata=0xA5…A5:
  - mem_read high 1 cycle after i_read.
  - mem_address=0x40.
  - i_resp single pulse 1 cycle after mem_resp, with i_rdata=0xA5…A5.
  - d_resp stays 0.
- D write-back to 0x1000_0000 with d_wdata=0x1234…:
  - mem_write held through BUSY with mem_wdata=0x1234…, mem_read=0.
  - d_resp pulse 1 cycle after mem_resp.
- i_read and d_read rise in the same cycle:
  - Default build: D served first, then I after one IDLE cycle.
  - With CACHE_ARB_ROUND_ROBIN_EN: first tie goes to D, next tie goes to I.
  - Check the addresses on mem_address in order.
- d_read and d_write both high:
  - mem_write=1, mem_read=0.
- Assert rst during BUSY (mem_resp not yet returned):
  - All outputs 0 in the same cycle (asynchronous).
  - After release, FSM is in IDLE.
  - A late mem_resp produces no x_resp.
- Spurious mem_resp in IDLE, then I requester drops i_read mid-BUSY:
  - Spurious mem_resp: no response, state stays IDLE.
  - Dropped i_read: i_resp still pulses once after mem_resp, then FSM returns to IDLE.
